if_fetch: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. Takes the current pc
//  and returns a 32-bit instruction to the IF/ID latch. Uses a direct-mapped instruction

---
 rtl/if_fetch_if.sv | 30 +++
 rtl/if_fetch.sv | 184 ++++++++++++++++++
 tb/tb_if_fetch.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if : byte-wide read port between the fetch stage and the memory controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface if_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_valid,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch : instruction fetch with a direct-mapped one-word-per-line I-cache
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_fetch #(
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [ADDR_W-1:0] i_pc,
  input  wire logic              i_jump_flag,
  input  wire logic              i_stall_in,
  if_fetch_if.master             bus,
  output logic                   o_stall_req,
  output logic [ADDR_W-1:0]      o_if_pc,
  output logic [31:0]            o_if_inst,
  output logic                   o_if_valid
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [31:0]         r_data [LINES];

  logic [ADDR_W-1:0]   r_miss_pc;
  logic [1:0]          r_cnt;
  logic [31:0]         r_buf;

  logic [ADDR_W-1:0]   r_if_pc;
  logic [31:0]         r_if_inst;
  logic                r_if_valid;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_miss_idx;
  logic [TAG_W-1:0]    w_miss_tag;
  logic                w_hit;

  logic                w_start;
  logic                w_take;
  logic                w_fill;
  logic                w_out_hit;
  logic                w_out_resp;
  logic                w_clr_valid;
  logic                w_stall_req;
  logic                w_mem_req;

  assign w_idx      = i_pc[IDX_W+1:2];
  assign w_tag      = i_pc[ADDR_W-1:IDX_W+2];
  assign w_miss_idx = r_miss_pc[IDX_W+1:2];
  assign w_miss_tag = r_miss_pc[ADDR_W-1:IDX_W+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_take      = 1'b0;
    w_fill      = 1'b0;
    w_out_hit   = 1'b0;
    w_out_resp  = 1'b0;
    w_clr_valid = 1'b0;
    w_stall_req = 1'b0;
    w_mem_req   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_jump_flag) begin
          w_clr_valid = 1'b1;
        end else if (!i_stall_in) begin
          if (w_hit) begin
            w_out_hit = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_stall_req = 1'b1;
            w_clr_valid = 1'b1;
            w_next      = MISS;
          end
        end
      end
      MISS: begin
        w_mem_req = 1'b1;
        // A redirect lets the PC load its target instead of being held.
        w_stall_req = !i_jump_flag;
        if (i_jump_flag) begin
          w_clr_valid = 1'b1;
          w_next      = IDLE;
        end else if (bus.mem_valid) begin
          w_take = 1'b1;
          if (r_cnt == 2'd3) begin
            w_fill = 1'b1;
            w_next = RESP;
          end
        end
      end
      RESP: begin
        if (i_jump_flag) begin
          w_clr_valid = 1'b1;
          w_next      = IDLE;
        end else if (!i_stall_in) begin
          w_out_resp = 1'b1;
          w_next     = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_miss_pc  <= '0;
      r_cnt      <= 2'd0;
      r_buf      <= 32'd0;
      r_if_pc    <= '0;
      r_if_inst  <= 32'd0;
      r_if_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_miss_pc <= {i_pc[ADDR_W-1:2], 2'b00};
        r_cnt     <= 2'd0;
      end
      if (w_take) begin
        case (r_cnt)
          2'd0:    r_buf[7:0]   <= bus.mem_rdata;
          2'd1:    r_buf[15:8]  <= bus.mem_rdata;
          2'd2:    r_buf[23:16] <= bus.mem_rdata;
          default: r_buf[31:24] <= bus.mem_rdata;
        endcase
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_fill) begin
        r_valid[w_miss_idx] <= 1'b1;
      end
      if (w_clr_valid) begin
        r_if_valid <= 1'b0;
      end
      if (w_out_hit) begin
        r_if_pc    <= i_pc;
        r_if_inst  <= r_data[w_idx];
        r_if_valid <= 1'b1;
      end
      if (w_out_resp) begin
        r_if_pc    <= r_miss_pc;
        r_if_inst  <= r_buf;
        r_if_valid <= 1'b1;
      end
    end
  end

  // Line storage needs no reset: the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_miss_idx] <= {bus.mem_rdata, r_buf[23:0]};
      r_tag[w_miss_idx]  <= w_miss_tag;
    end
  end

  assign bus.mem_req  = w_mem_req;
  assign bus.mem_addr = w_mem_req ? (r_miss_pc + {{(ADDR_W-2){1'b0}}, r_cnt}) : '0;
  assign o_stall_req  = rst & w_stall_req;
  assign o_if_pc      = r_if_pc;
  assign o_if_inst    = r_if_inst;
  assign o_if_valid   = r_if_valid;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch : directed scoreboard bench for if_fetch
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        jump_flag = 1'b0;
  logic        stall_in = 1'b1;
  logic        stall_req;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  always #5 clk = ~clk;

  if_fetch_if #(.ADDR_W(32)) bus ();

  if_fetch #(.IDX_W(6), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_pc       (pc),
    .i_jump_flag(jump_flag),
    .i_stall_in (stall_in),
    .bus        (bus),
    .o_stall_req(stall_req),
    .o_if_pc    (if_pc),
    .o_if_inst  (if_inst),
    .o_if_valid (if_valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] addr_log[$];
  logic [7:0]  mem[logic [31:0]];
  int          budget = 0;
  int          out_count = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    mem[a]     = w[7:0];
    mem[a + 1] = w[15:8];
    mem[a + 2] = w[23:16];
    mem[a + 3] = w[31:24];
  endtask

  // Memory model: answers one byte per cycle while the budget lasts.
  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst && bus.mem_req && budget > 0) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 8'h00;
        addr_log.push_back(bus.mem_addr);
        budget--;
      end else begin
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 8'h00;
      end
    end
  end

  // Monitor: a fresh IF/ID word appears after any edge where outputs were not held.
  initial begin
    logic held;
    exp_t e;
    forever begin
      @(posedge clk);
      held = stall_in || !rst;
      @(negedge clk);
      if (rst && if_valid && !held) begin
        out_count++;
        if (sb.size() == 0) begin
          chk("unexpected_output_pc", if_pc, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_pc", if_pc, e.pc);
          chk("out_inst", if_inst, e.inst);
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] w, input bit miss, input string nm);
    int   start;
    int   hi;
    bit   done;
    exp_t e;
    start = out_count;
    done  = 1'b0;
    addr_log.delete();
    e.pc   = a;
    e.inst = w;
    sb.push_back(e);
    pc       = a;
    stall_in = 1'b0;
    #1;
    chk({nm, "_stall_req_now"}, {31'd0, stall_req}, {31'd0, miss});
    hi = stall_req ? 1 : 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #1;
      if (out_count != start) done = 1'b1;
      else if (stall_req) hi++;
    end
    stall_in = 1'b1;
    chk({nm, "_completed"}, {31'd0, done}, 32'd1);
    chk({nm, "_mem_bytes"}, addr_log.size(), miss ? 32'd4 : 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (miss && k < addr_log.size())
        chk({nm, "_mem_addr"}, addr_log[k], a + k);
    end
    chk({nm, "_stall_cycles"}, hi, miss ? 32'd5 : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    put_word(32'h0000_0000, 32'h0050_0013);
    put_word(32'h0000_0004, 32'h00A0_0093);
    put_word(32'h0000_0008, 32'h4433_2211);
    put_word(32'h0000_0020, 32'h1234_5678);
    put_word(32'h0000_0040, 32'h1000_0137);
    put_word(32'h0000_0100, 32'h0010_0093);
    put_word(32'h0000_0200, 32'h0031_01B3);

    #12;
    chk("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr",  bus.mem_addr, 32'd0);
    chk("rst_stall_req", {31'd0, stall_req}, 32'd0);
    chk("rst_if_pc",     if_pc, 32'd0);
    chk("rst_if_inst",   if_inst, 32'd0);
    chk("rst_if_valid",  {31'd0, if_valid}, 32'd0);

    // Reset while a miss is two bytes in.
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    budget = 2;
    addr_log.delete();
    pc = 32'h20;
    stall_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t1_bytes_before_reset", addr_log.size(), 32'd2);
    rst = 1'b0;
    #1;
    chk("t1_mem_req",   {31'd0, bus.mem_req}, 32'd0);
    chk("t1_mem_addr",  bus.mem_addr, 32'd0);
    chk("t1_stall_req", {31'd0, stall_req}, 32'd0);
    chk("t1_if_valid",  {31'd0, if_valid}, 32'd0);
    chk("t1_if_pc",     if_pc, 32'd0);
    chk("t1_if_inst",   if_inst, 32'd0);
    stall_in = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;
    budget = 1000;
    @(negedge clk); #1;
    fetch(32'h20, 32'h1234_5678, 1'b1, "t1_refetch");

    fetch(32'h0, 32'h0050_0013, 1'b1, "t2_cold");
    fetch(32'h0, 32'h0050_0013, 1'b0, "t3_hit");
    fetch(32'h100, 32'h0010_0093, 1'b1, "t4_conflict");
    fetch(32'h0, 32'h0050_0013, 1'b1, "t4_evicted");

    // Redirect after byte 0; byte 1 arrives in the jump cycle and must be dropped.
    budget = 2;
    addr_log.delete();
    pc = 32'h8;
    stall_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    jump_flag = 1'b1;
    pc = 32'h40;
    @(negedge clk);
    chk("t5_mem_req_after_jump",  {31'd0, bus.mem_req}, 32'd0);
    chk("t5_if_valid_after_jump", {31'd0, if_valid}, 32'd0);
    chk("t5_bytes_seen",          addr_log.size(), 32'd2);
    #1;
    jump_flag = 1'b0;
    stall_in = 1'b1;
    budget = 1000;
    @(negedge clk); #1;
    fetch(32'h40, 32'h1000_0137, 1'b1, "t5_target");
    fetch(32'h8, 32'h4433_2211, 1'b1, "t5_no_partial_write");

    fetch(32'h4, 32'h00A0_0093, 1'b1, "t6_load");
    pc = 32'h200;
    addr_log.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_hold_inst",  if_inst, 32'h00A0_0093);
      chk("t6_hold_pc",    if_pc, 32'h4);
      chk("t6_hold_valid", {31'd0, if_valid}, 32'd1);
      chk("t6_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
    end
    #1;
    fetch(32'h200, 32'h0031_01B3, 1'b1, "t6_resume");
    fetch(32'h4, 32'h00A0_0093, 1'b0, "t6_hit");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
